pipelined_addsub: RTL and testbench

- Parametrised successor to the team's 32-bit ripple adder.
- Computes A+B+cin or A-B-(borrow) over WIDTH bits.
- Carry chain is split into STAGES registered slices; throughput is one operation per clock.
- Valid/ready handshake on both sides, backpressure supported, status flags returned with each result.
- Sits between operand-producing datapath logic and ALU result consumers in the lab CPU datapath.

---
 rtl/addsub_pkg.sv | 16 +
 rtl/addsub_slice.sv | 29 ++
 rtl/pipelined_addsub.sv | 142 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared mode encodings and slice sizing for the pipelined adder/subtractor.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Returns 0 when the width cannot be split into equal slices.
    function automatic int slice_width(input int width, input int stages);
        if ((stages < 1) || (stages > width) || ((width % stages) != 0)) begin
            return 0;
        end else begin
            return width / stages;
        end
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// One combinational W-bit ripple slice of the pipelined carry chain.
module addsub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_chunk,
    input  logic [W-1:0] b_chunk,
    input  logic         cin,
    output logic [W-1:0] sum_chunk,
    output logic         cout,
    output logic         cin_msb
);

    logic [W:0] carry_s;

    // Ripple the carry bit by bit through the chunk
    always_comb begin
        carry_s    = {(W+1){1'b0}};
        sum_chunk  = {W{1'b0}};
        carry_s[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum_chunk[i]  = a_chunk[i] ^ b_chunk[i] ^ carry_s[i];
            carry_s[i+1]  = (a_chunk[i] & b_chunk[i]) | (carry_s[i] & (a_chunk[i] ^ b_chunk[i]));
        end
    end

    assign cout    = carry_s[W];
    assign cin_msb = carry_s[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract with the carry chain cut into STAGES registered slices
// and a valid/ready handshake that stalls the whole pipe on backpressure.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int W = slice_width(WIDTH, STAGES);

    if (W == 0) begin : g_param_check
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    logic             adv_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c_eff_s;
    logic             ovf_r;
    logic             zero_r;

    assign adv_s    = ~out_valid | out_ready;
    assign in_ready = adv_s;

    // Subtraction is a + ~b + ~borrow
    always_comb begin
        b_eff_s = b;
        c_eff_s = ci;
        if (sub == MODE_SUB) begin
            b_eff_s = ~b;
            c_eff_s = ~ci;
        end else begin
            b_eff_s = b;
            c_eff_s = ci;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int RW = WIDTH - k * W;   // operand bits not yet consumed, incl. this chunk
        localparam int LW = (k + 1) * W;     // result bits known after this slice

        logic [RW-1:0] a_cur_s;
        logic [RW-1:0] b_cur_s;
        logic          c_cur_s;
        logic          v_cur_s;
        logic [W-1:0]  sum_chunk_s;
        logic          cout_s;
        logic          cin_msb_s;
        logic [LW-1:0] s_nxt_s;
        logic [LW-1:0] s_r;
        logic          v_r;
        logic          c_r;

        if (k == 0) begin : g_src
            assign a_cur_s = a;
            assign b_cur_s = b_eff_s;
            assign c_cur_s = c_eff_s;
            assign v_cur_s = in_valid;
            assign s_nxt_s = sum_chunk_s;
        end else begin : g_src
            assign a_cur_s = stg[k-1].g_ops.a_r;
            assign b_cur_s = stg[k-1].g_ops.b_r;
            assign c_cur_s = stg[k-1].c_r;
            assign v_cur_s = stg[k-1].v_r;
            assign s_nxt_s = {sum_chunk_s, stg[k-1].s_r};
        end

        addsub_slice #(.W(W)) u_slice (
            .a_chunk   (a_cur_s[W-1:0]),
            .b_chunk   (b_cur_s[W-1:0]),
            .cin       (c_cur_s),
            .sum_chunk (sum_chunk_s),
            .cout      (cout_s),
            .cin_msb   (cin_msb_s)
        );

        // Stage valid, carry and accumulated low result bits
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= {LW{1'b0}};
            end else if (adv_s) begin
                v_r <= v_cur_s;
                c_r <= cout_s;
                s_r <= s_nxt_s;
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [RW-W-1:0] a_r;
            logic [RW-W-1:0] b_r;
            logic            unused_cin_msb_s;

            assign unused_cin_msb_s = cin_msb_s;

            // Upper operand chunks still waiting for their slice
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_r <= {(RW-W){1'b0}};
                    b_r <= {(RW-W){1'b0}};
                end else if (adv_s) begin
                    a_r <= a_cur_s[RW-1:W];
                    b_r <= b_cur_s[RW-1:W];
                end
            end
        end else begin : g_flags
            // Full-width status flags, registered alongside the final sum
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_r  <= 1'b0;
                    zero_r <= 1'b0;
                end else if (adv_s) begin
                    ovf_r  <= cin_msb_s ^ cout_s;
                    zero_r <= (s_nxt_s == {LW{1'b0}});
                end
            end
        end
    end

    assign out_valid = stg[STAGES-1].v_r;
    assign f         = stg[STAGES-1].s_r;
    assign co        = stg[STAGES-1].c_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench: directed 32-bit vectors plus 8-bit sweeps at STAGES = 1, 2, 8.
module tb_pipelined_addsub;

    localparam int LAT = 4;

    typedef struct {
        logic [31:0] f;
        logic        co;
        logic        ovf;
        logic        zero;
        int          lat_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, sub, ci, out_valid, out_ready, co, ovf, zero;
    logic [31:0] a, b, f;
    bit          sweep_go = 1'b0;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pipelined_addsub #(.WIDTH(32), .STAGES(LAT)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .ci(ci),
        .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .co(co), .ovf(ovf), .zero(zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic sv, input logic cv,
                        input logic [31:0] ef, input logic eco, input logic eovf, input logic ez,
                        input bit chk);
        int   n;
        exp_t e;
        a = av; b = bv; sub = sv; ci = cv; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
        end else begin
            e.f = ef; e.co = eco; e.ovf = eovf; e.zero = ez;
            e.lat_cyc = chk ? cyc + LAT : -1;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [10:0] model8(input logic [7:0] av, input logic [7:0] bv,
                                           input logic sv, input logic cv);
        logic [7:0] be;
        logic       ce;
        logic [8:0] s;
        logic [7:0] fv;
        be = sv ? ~bv : bv;
        ce = sv ? ~cv : cv;
        s  = {1'b0, av} + {1'b0, be} + {8'd0, ce};
        fv = s[7:0];
        return {fv == 8'd0, (av[7] == be[7]) && (fv[7] != av[7]), s[8], fv};
    endfunction

    // Pops and compares every result the 32-bit instance hands over
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_beat: got f=%h, expected no output", f);
            end else begin
                mon_e = sb_q.pop_front();
                check("f", f, mon_e.f);
                check("co", {31'd0, co}, {31'd0, mon_e.co});
                check("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
                check("zero", {31'd0, zero}, {31'd0, mon_e.zero});
                if (mon_e.lat_cyc >= 0) check("latency", cyc, mon_e.lat_cyc);
            end
        end
        if (!rst && out_valid && !out_ready) check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end

    for (genvar j = 0; j < 3; j++) begin : sw
        localparam int STG = (j == 0) ? 1 : ((j == 1) ? 2 : 8);

        logic        iv, ir, ov, ordy, sb8, c8, co8, ovf8, z8;
        logic [7:0]  a8, b8, f8;
        logic [10:0] q8[$];
        logic [10:0] exp8;
        bit          done = 1'b0;

        pipelined_addsub #(.WIDTH(8), .STAGES(STG)) u_dut (
            .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
            .a(a8), .b(b8), .sub(sb8), .ci(c8),
            .out_valid(ov), .out_ready(ordy),
            .f(f8), .co(co8), .ovf(ovf8), .zero(z8)
        );

        initial begin
            int cnt;
            iv = 1'b0; a8 = 8'd0; b8 = 8'd0; sb8 = 1'b0; c8 = 1'b0; ordy = 1'b1;
            cnt = 0;
            wait (sweep_go);
            @(posedge clk); #1;
            while (cnt < 1000) begin
                iv   = ($urandom_range(0, 4) != 0);
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                sb8  = 1'($urandom);
                c8   = 1'($urandom);
                ordy = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (iv && ir) begin
                    q8.push_back(model8(a8, b8, sb8, c8));
                    cnt++;
                end
                @(posedge clk); #1;
            end
            iv = 1'b0; ordy = 1'b1;
            for (int n = 0; n < 100 && q8.size() != 0; n++) @(posedge clk);
            if (q8.size() != 0) begin
                n_vec++; n_bad++;
                $display("FAIL sweep%0d_drain: %0d results outstanding, expected 0", STG, q8.size());
            end
            done = 1'b1;
        end

        always @(negedge clk) begin
            if (!rst && ov && ordy) begin
                if (q8.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL sweep%0d_unexpected: got f=%h, expected no output", STG, f8);
                end else begin
                    exp8 = q8.pop_front();
                    check($sformatf("sweep%0d_result", STG), {21'd0, z8, ovf8, co8, f8}, {21'd0, exp8});
                end
            end
            if (!rst && ov && !ordy) check($sformatf("sweep%0d_stall_in_ready", STG), {31'd0, ir}, 32'd0);
        end
    end

    initial begin
        int n;
        in_valid = 1'b0; a = 32'd0; b = 32'd0; sub = 1'b0; ci = 1'b0; out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_f", f, 32'd0);
        check("rst_flags", {29'd0, co, ovf, zero}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        send(32'd124,        32'd1441,  1'b0, 1'b0, 32'd1565,       1'b0, 1'b0, 1'b0, 1'b1);
        send(32'd412412,     32'd90809, 1'b0, 1'b0, 32'd503221,     1'b0, 1'b0, 1'b0, 1'b1);
        send(32'hFFFFFFFF,   32'd1,     1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 1'b1, 1'b1);
        send(32'h7FFFFFFF,   32'd1,     1'b0, 1'b0, 32'h80000000,   1'b0, 1'b1, 1'b0, 1'b1);
        send(32'd5,          32'd6,     1'b0, 1'b1, 32'd12,         1'b0, 1'b0, 1'b0, 1'b1);
        send(32'd10,         32'd3,     1'b1, 1'b0, 32'd7,          1'b1, 1'b0, 1'b0, 1'b1);
        send(32'd3,          32'd10,    1'b1, 1'b0, 32'hFFFFFFF9,   1'b0, 1'b0, 1'b0, 1'b1);
        send(32'h80000000,   32'd1,     1'b1, 1'b0, 32'h7FFFFFFF,   1'b1, 1'b1, 1'b0, 1'b1);
        send(32'd10,         32'd3,     1'b1, 1'b1, 32'd6,          1'b1, 1'b0, 1'b0, 1'b1);
        send(32'd5,          32'd5,     1'b1, 1'b0, 32'd0,          1'b1, 1'b0, 1'b1, 1'b1);
        drain();

        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(32'(i), 32'(i), 1'b0, 1'b0, 32'(2 * i), 1'b0, 1'b0, (i == 0), 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        send(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h7FFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        send(32'd100,      32'd200,      1'b0, 1'b0, 32'd300,      1'b0, 1'b0, 1'b0, 1'b0);
        send(32'd7,        32'd9,        1'b0, 1'b0, 32'd16,       1'b0, 1'b0, 1'b0, 1'b0);
        send(32'd1,        32'd1,        1'b0, 1'b0, 32'd2,        1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_f", f, 32'd0);
        check("midrst_flags", {29'd0, co, ovf, zero}, 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        send(32'd20, 32'd22, 1'b0, 1'b0, 32'd42, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        sweep_go = 1'b1;
        n = 0;
        while (!(sw[0].done && sw[1].done && sw[2].done) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (!(sw[0].done && sw[1].done && sw[2].done)) begin
            n_vec++; n_bad++;
            $display("FAIL sweep_timeout: done=%b%b%b, expected 111", sw[2].done, sw[1].done, sw[0].done);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
